// File: rtl/instruction_aligner.sv
// Repacks word-aligned 32-bit fetch words into a 3-halfword buffer and issues one RVC or 32-bit instruction per handshake with its PC.
// Issue latency 1 cycle after accept; fetch_ready depends only on registered occupancy (cnt <= 1); flush overrides accept and issue.
module instruction_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_word_i,
  output logic        fetch_ready_o,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_is_rvc_o
);

  logic [15:0] hb_q   [3];
  logic [15:0] hb_nxt [3];
  logic [1:0]  cnt_q, cnt_nxt;
  logic [31:0] pc_q;
  logic        skip_q;

  logic        head_rvc, head_avail, accept, issue;
  logic [1:0]  pop_n, push_n, remain;

  assign head_rvc   = (hb_q[0][1:0] != 2'b11);
  assign head_avail = head_rvc ? (cnt_q >= 2'd1) : (cnt_q >= 2'd2);

  assign fetch_ready_o  = (cnt_q <= 2'd1);
  assign instr_valid_o  = head_avail & ~flush_i;
  assign instr_is_rvc_o = head_avail & head_rvc;
  assign instr_pc_o     = pc_q;

  always_comb begin
    instr_o = 32'h0000_0000;
    if (head_avail) begin
      instr_o = head_rvc ? {16'h0000, hb_q[0]} : {hb_q[1], hb_q[0]};
    end
  end

  assign accept = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign issue  = instr_valid_o & instr_ready_i;
  assign pop_n  = issue ? (head_rvc ? 2'd1 : 2'd2) : 2'd0;
  assign push_n = accept ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
  assign remain = cnt_q - pop_n;

  // Accept only happens at cnt <= 1, so remain is 0 or 1 and the push fits.
  always_comb begin
    hb_nxt = hb_q;
    if (pop_n == 2'd1) begin
      hb_nxt[0] = hb_q[1];
      hb_nxt[1] = hb_q[2];
    end else if (pop_n == 2'd2) begin
      hb_nxt[0] = hb_q[2];
    end
    if (accept) begin
      if (skip_q) begin
        if (remain[0]) hb_nxt[1] = fetch_word_i[31:16];
        else           hb_nxt[0] = fetch_word_i[31:16];
      end else if (remain[0]) begin
        hb_nxt[1] = fetch_word_i[15:0];
        hb_nxt[2] = fetch_word_i[31:16];
      end else begin
        hb_nxt[0] = fetch_word_i[15:0];
        hb_nxt[1] = fetch_word_i[31:16];
      end
    end
    cnt_nxt = cnt_q - pop_n + push_n;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q  <= 2'd0;
      pc_q   <= {RESET_PC[31:1], 1'b0};
      skip_q <= RESET_PC[1];
      hb_q   <= '{default: 16'h0000};
    end else if (flush_i) begin
      cnt_q  <= 2'd0;
      pc_q   <= {flush_pc_i[31:1], 1'b0};
      skip_q <= flush_pc_i[1];
    end else begin
      cnt_q <= cnt_nxt;
      hb_q  <= hb_nxt;
      if (issue) pc_q <= pc_q + (head_rvc ? 32'd2 : 32'd4);
      if (accept) skip_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_aligner.sv
// Random and directed stimulus against a halfword-stream model; expected instructions are queued and popped by a monitor on each issue.
module tb_instruction_aligner;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_word_i;
  logic        fetch_ready_o;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_is_rvc_o;

  instruction_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fetch_valid_i(fetch_valid_i), .fetch_word_i(fetch_word_i), .fetch_ready_o(fetch_ready_o),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_is_rvc_o(instr_is_rvc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rvc;
    int          hw;
  } exp_t;

  typedef struct {
    logic        fv;
    logic [31:0] w;
    logic        fl;
    logic [31:0] fpc;
    logic        rdy;
  } stim_t;

  exp_t        exp_q[$];
  logic [15:0] pend[$];
  logic [31:0] mpc;
  logic        mskip;
  logic        p_acc, p_flush;
  logic [31:0] p_word, p_fpc;
  int          checks = 0;
  int          errors = 0;
  int          issued = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int occupancy();
    int o = pend.size();
    foreach (exp_q[i]) o += exp_q[i].hw;
    return o;
  endfunction

  // Turns buffered halfwords into whole instructions as soon as enough are present.
  task automatic decode();
    exp_t e;
    while (pend.size() > 0) begin
      if (pend[0][1:0] != 2'b11) begin
        e.instr = {16'h0000, pend[0]}; e.pc = mpc; e.rvc = 1'b1; e.hw = 1;
        exp_q.push_back(e);
        mpc = mpc + 32'd2;
        void'(pend.pop_front());
      end else if (pend.size() >= 2) begin
        e.instr = {pend[1], pend[0]}; e.pc = mpc; e.rvc = 1'b0; e.hw = 2;
        exp_q.push_back(e);
        mpc = mpc + 32'd4;
        void'(pend.pop_front());
        void'(pend.pop_front());
      end else begin
        break;
      end
    end
  endtask

  task automatic model_reset(input logic [31:0] pc);
    exp_q.delete();
    pend.delete();
    mpc     = {pc[31:1], 1'b0};
    mskip   = pc[1];
    p_acc   = 1'b0;
    p_flush = 1'b0;
  endtask

  task automatic apply_pending();
    if (p_flush) begin
      model_reset(p_fpc);
    end else if (p_acc) begin
      if (!mskip) pend.push_back(p_word[15:0]);
      pend.push_back(p_word[31:16]);
      mskip = 1'b0;
      decode();
    end
    p_acc   = 1'b0;
    p_flush = 1'b0;
  endtask

  task automatic drive(input stim_t s);
    @(posedge clk_i);
    #1;
    apply_pending();
    fetch_valid_i = s.fv;
    fetch_word_i  = s.w;
    flush_i       = s.fl;
    flush_pc_i    = s.fpc;
    instr_ready_i = s.rdy;
    p_flush = s.fl;
    p_fpc   = s.fpc;
    p_word  = s.w;
    p_acc   = s.fv && (occupancy() <= 1) && !s.fl;
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h = 16'($urandom);
    if ($urandom_range(1, 0) == 1) h[1:0] = 2'b11;
    return h;
  endfunction

  // Monitor: sample mid-cycle, compare against the scoreboard head, pop on handshake.
  always @(negedge clk_i) begin
    if (rst_i) begin
      logic ev;
      ev = (exp_q.size() > 0) && !flush_i;
      chk("fetch_ready", {31'd0, fetch_ready_o}, {31'd0, occupancy() <= 1});
      chk("instr_valid", {31'd0, instr_valid_o}, {31'd0, ev});
      if (ev && instr_valid_o) begin
        chk("instr", instr_o, exp_q[0].instr);
        chk("instr_pc", instr_pc_o, exp_q[0].pc);
        chk("is_rvc", {31'd0, instr_is_rvc_o}, {31'd0, exp_q[0].rvc});
        if (instr_ready_i) begin
          void'(exp_q.pop_front());
          issued++;
        end
      end
    end
  end

  stim_t dir[$];
  stim_t s;

  function automatic stim_t st(input logic fv, input logic [31:0] w, input logic fl,
                               input logic [31:0] fpc, input logic rdy);
    stim_t r;
    r.fv = fv; r.w = w; r.fl = fl; r.fpc = fpc; r.rdy = rdy;
    return r;
  endfunction

  initial begin
    rst_i = 1'b0;
    fetch_valid_i = 1'b0; fetch_word_i = '0; flush_i = 1'b0; flush_pc_i = '0; instr_ready_i = 1'b0;
    model_reset(32'h0000_0000);

    repeat (2) @(posedge clk_i);
    #3;
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_fetch_ready", {31'd0, fetch_ready_o}, 32'd1);
    chk("rst_pc", instr_pc_o, 32'h0000_0000);
    chk("rst_instr", instr_o, 32'h0000_0000);
    chk("rst_rvc", {31'd0, instr_is_rvc_o}, 32'd0);
    rst_i = 1'b1;

    dir.push_back(st(1, 32'h00A0_0513, 0, 0, 1));
    dir.push_back(st(0, 0, 0, 0, 1));
    dir.push_back(st(1, 32'h4505_4505, 0, 0, 0));
    dir.push_back(st(0, 0, 0, 0, 0));
    dir.push_back(st(0, 0, 0, 0, 1));
    dir.push_back(st(0, 0, 0, 0, 1));
    dir.push_back(st(1, 32'h0513_0001, 0, 0, 1));
    dir.push_back(st(0, 0, 0, 0, 1));
    dir.push_back(st(0, 0, 0, 0, 1));
    dir.push_back(st(1, 32'h1234_00A0, 0, 0, 1));
    repeat (3) dir.push_back(st(0, 0, 0, 0, 1));
    dir.push_back(st(1, 32'h4505_4505, 0, 0, 0));
    dir.push_back(st(0, 0, 0, 0, 0));
    dir.push_back(st(0, 0, 1, 32'h0000_0102, 0));
    dir.push_back(st(1, 32'h4505_0001, 0, 0, 1));
    repeat (2) dir.push_back(st(0, 0, 0, 0, 1));
    repeat (5) dir.push_back(st(1, 32'h0001_0513, 0, 0, 0));
    dir.push_back(st(1, 32'h2222_1111, 1, 32'h0000_0200, 0));
    dir.push_back(st(1, 32'h4505_4505, 0, 0, 1));
    repeat (2) dir.push_back(st(0, 0, 0, 0, 1));
    dir.push_back(st(0, 0, 1, 32'hFFFF_FFFD, 1));
    dir.push_back(st(1, 32'h4505_4505, 0, 0, 1));
    dir.push_back(st(1, 32'h00A0_0513, 0, 0, 1));
    dir.push_back(st(1, 32'h0513_4505, 0, 0, 1));
    repeat (4) dir.push_back(st(0, 0, 0, 0, 1));
    foreach (dir[i]) drive(dir[i]);

    for (int n = 0; n < 3000; n++) begin
      s.fv  = ($urandom_range(9, 0) < 7);
      s.w   = {rand_hw(), rand_hw()};
      s.fl  = ($urandom_range(99, 0) < 3);
      s.fpc = $urandom;
      s.rdy = ($urandom_range(9, 0) < 7);
      drive(s);
    end

    for (int n = 0; n < 20 && exp_q.size() > 0; n++) drive(st(0, 0, 0, 0, 1));
    drive(st(0, 0, 0, 0, 1));
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("issued_enough", {31'd0, issued > 500}, 32'd1);

    drive(st(1, 32'h4505_4505, 0, 0, 0));
    drive(st(0, 0, 0, 0, 0));
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    fetch_valid_i = 1'b0; flush_i = 1'b0; instr_ready_i = 1'b1;
    model_reset(32'h0000_0000);
    #1;
    chk("midrst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("midrst_fetch_ready", {31'd0, fetch_ready_o}, 32'd1);
    chk("midrst_pc", instr_pc_o, 32'h0000_0000);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    drive(st(1, 32'h00A0_0513, 0, 0, 1));
    repeat (3) drive(st(0, 0, 0, 0, 1));
    chk("post_rst_issued", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
